ws2812_in: RTL and testbench

//  Decodes a WS2812 (NeoPixel) single-wire stream back into bits and 24-bit GRB words.
//  It measures high-pulse width, classifies each pulse as 0/1, assembles MSB-first words,
//  and flags the inter-frame reset gap.
//  It sits on a loopback/daisy-chain input pin, used for self-test of the LED output path
//  and for chaining controllers.

---
 rtl/ws2812_pkg.sv | 25 ++
 rtl/edge2en.sv | 31 +++
 rtl/ws2812_in.sv | 134 +++++++++++++
 tb/tb_ws2812_in.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing constants (clk_in cycles at 200 MHz) for the LED encoder and loopback decoder.
package ws2812_pkg;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned WORD_BITS = 24;
  localparam int unsigned IDX_W     = 5;

  // Encoder-side nominal waveform.
  localparam logic [CNT_W-1:0] T0H_CNT    = 16'd70;
  localparam logic [CNT_W-1:0] T1H_CNT    = 16'd140;
  localparam logic [CNT_W-1:0] PERIOD_CNT = 16'd250;
  localparam logic [CNT_W-1:0] RESET_CNT  = 16'd10000;

  // Decoder-side classification limits.
  localparam logic [CNT_W-1:0] MIN_HIGH_CNT  = 16'd20;
  localparam logic [CNT_W-1:0] THRESHOLD_CNT = 16'd105;
  localparam logic [CNT_W-1:0] MAX_HIGH_CNT  = 16'd250;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

endpackage

// File: rtl/edge2en.sv
// Registered rise/fall enables plus the level aligned with them.
module edge2en (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
      rise_q <= sig_i & ~prev_q;
      fall_q <= ~sig_i & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ws2812_in.sv
// WS2812 loopback decoder: pulse-width classification, MSB-first GRB word assembly, frame-gap detection.
module ws2812_in
  import ws2812_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MIN_HIGH  = MIN_HIGH_CNT,
  parameter logic [CNT_W-1:0] CNT_THRESHOLD = THRESHOLD_CNT,
  parameter logic [CNT_W-1:0] CNT_MAX_HIGH  = MAX_HIGH_CNT,
  parameter logic [CNT_W-1:0] CNT_RESET     = RESET_CNT
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 ws2812_data_in,
  output logic                 bit_vld_out,
  output logic                 bit_data_out,
  output logic                 word_vld_out,
  output logic [WORD_BITS-1:0] word_data_out,
  output logic                 frame_done_out,
  output logic                 err_out
);

  localparam logic [CNT_W-1:0] HIGH_SAT = CNT_MAX_HIGH + 16'd1;
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_RESET - 16'd1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BITS - 1);

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 level_c;
  logic                 rise_c;
  logic                 fall_c;
  logic [CNT_W-1:0]     high_cnt_q;
  logic [CNT_W-1:0]     low_cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [WORD_BITS-1:0] shift_q;
  logic [WORD_BITS-1:0] word_q;
  logic                 armed_q;
  logic                 bit_vld_q;
  logic                 bit_data_q;
  logic                 word_vld_q;
  logic                 frame_done_q;
  logic                 err_q;
  logic                 dec_bit_c;
  logic [WORD_BITS-1:0] shift_next_c;

  edge2en u_edge2en (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .sig_i    (sync2_q),
    .level_o  (level_c),
    .rise_o   (rise_c),
    .fall_o   (fall_c)
  );

  assign dec_bit_c    = (high_cnt_q > CNT_THRESHOLD);
  assign shift_next_c = {shift_q[WORD_BITS-2:0], dec_bit_c};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      armed_q      <= 1'b0;
      bit_vld_q    <= 1'b0;
      bit_data_q   <= 1'b0;
      word_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync1_q      <= ws2812_data_in;
      sync2_q      <= sync1_q;
      bit_vld_q    <= 1'b0;
      word_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;

      // High width, saturating one past the legal maximum so over-long pulses stay detectable.
      if (rise_c) begin
        high_cnt_q <= 16'd1;
      end else if (level_c && (high_cnt_q != HIGH_SAT)) begin
        high_cnt_q <= high_cnt_q + 16'd1;
      end

      // Low gap; frame_done fires only on the step into saturation, so once per low period.
      if (rise_c) begin
        low_cnt_q <= '0;
      end else if (!level_c && (low_cnt_q != CNT_RESET)) begin
        low_cnt_q <= low_cnt_q + 16'd1;
        if (low_cnt_q == LOW_LAST) begin
          frame_done_q <= 1'b1;
          bit_idx_q    <= '0;
          shift_q      <= '0;
          if (bit_idx_q != '0) begin
            err_q <= 1'b1;
          end
        end
      end

      // The first fall after reset only arms, so a line high at reset exit is ignored.
      if (fall_c) begin
        if (!armed_q) begin
          armed_q <= 1'b1;
        end else if (high_cnt_q < CNT_MIN_HIGH) begin
          err_q <= 1'b1;
        end else if (high_cnt_q > CNT_MAX_HIGH) begin
          err_q     <= 1'b1;
          bit_idx_q <= '0;
          shift_q   <= '0;
        end else begin
          bit_vld_q  <= 1'b1;
          bit_data_q <= dec_bit_c;
          shift_q    <= shift_next_c;
          if (bit_idx_q == IDX_LAST) begin
            word_q     <= shift_next_c;
            word_vld_q <= 1'b1;
            bit_idx_q  <= '0;
          end else begin
            bit_idx_q <= bit_idx_q + IDX_W'(1);
          end
        end
      end
    end
  end

  assign bit_vld_out    = bit_vld_q;
  assign bit_data_out   = bit_data_q;
  assign word_vld_out   = word_vld_q;
  assign word_data_out  = word_q;
  assign frame_done_out = frame_done_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_ws2812_in.sv
// Self-checking bench for ws2812_in: pulse-level reference model compared event-by-event.
module tb_ws2812_in;
  import ws2812_pkg::*;

  typedef struct packed {
    logic        bv;
    logic        bd;
    logic        wv;
    logic [23:0] w;
    logic        fd;
    logic        er;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        bv, bd, wv, fd, er;
  logic [23:0] wd;

  int checks = 0;
  int failures = 0;

  ev_t obs_q[$];
  ev_t exp_q[$];

  // Reference model state, expressed in whole pulses and low runs.
  bit          m_armed;
  int          m_idx;
  logic [23:0] m_sh;
  logic [23:0] m_word;
  int          m_low;
  bit          m_fd_done;

  always #5 clk = ~clk;

  ws2812_in dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .ws2812_data_in (din),
    .bit_vld_out    (bv),
    .bit_data_out   (bd),
    .word_vld_out   (wv),
    .word_data_out  (wd),
    .frame_done_out (fd),
    .err_out        (er)
  );

  function automatic ev_t mk(input logic v, input logic d, input logic wvl,
                             input logic [23:0] w, input logic f, input logic e);
    ev_t r;
    r.bv = v;
    r.bd = v ? d : 1'b0;
    r.wv = wvl;
    r.w  = wvl ? w : 24'h0;
    r.fd = f;
    r.er = e;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (bv || wv || fd || er)) obs_q.push_back(mk(bv, bd, wv, wd, fd, er));
  end

  initial begin
    #1500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_armed = 1'b0; m_idx = 0; m_sh = '0; m_word = '0; m_low = 0; m_fd_done = 1'b0;
  endtask

  task automatic model_pulse(input int w);
    logic b;
    m_low = 0;
    m_fd_done = 1'b0;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else if (w < int'(MIN_HIGH_CNT)) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
    end else if (w > int'(MAX_HIGH_CNT)) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
      m_idx = 0; m_sh = '0;
    end else begin
      b = (w > int'(THRESHOLD_CNT));
      m_sh = {m_sh[22:0], b};
      if (m_idx == 23) begin
        m_word = m_sh;
        exp_q.push_back(mk(1, b, 1, m_sh, 0, 0));
        m_idx = 0;
      end else begin
        exp_q.push_back(mk(1, b, 0, 0, 0, 0));
        m_idx++;
      end
    end
  endtask

  task automatic hi(input int w);
    din = 1'b1;
    repeat (w) @(negedge clk);
    model_pulse(w);
  endtask

  task automatic lo(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
    m_low += n;
    if (!m_fd_done && m_low >= int'(RESET_CNT)) begin
      m_fd_done = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 1, m_idx != 0));
      m_idx = 0; m_sh = '0;
    end
  endtask

  // Sends bits w[from] down to w[to]; rnd picks random legal widths and short random lows.
  task automatic send_bits(input logic [23:0] w, input int from, input int to, input bit rnd);
    int hw, lw;
    for (int i = from; i >= to; i--) begin
      if (rnd) begin
        hw = w[i] ? int'($urandom_range(106, 250)) : int'($urandom_range(20, 105));
        lw = int'($urandom_range(10, 120));
      end else begin
        hw = w[i] ? int'(T1H_CNT) : int'(T0H_CNT);
        lw = int'(PERIOD_CNT) - hw;
      end
      hi(hw);
      lo(lw);
    end
  endtask

  task automatic flush_check(input string tag);
    int n;
    repeat (8) @(negedge clk);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_event"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {3'b0, bv, bd, wv, wd, fd, er}, 32'h0);
  endtask

  initial begin
    logic [23:0] w;
    model_reset();
    repeat (5) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;

    // Priming pulse: the first fall after reset only arms the decoder.
    lo(20);
    hi(int'(T0H_CNT));
    lo(180);
    flush_check("prime");

    // Nominal word then a frame gap.
    send_bits(24'h00FF81, 23, 0, 1'b0);
    lo(12000);
    flush_check("nominal");
    chk("word_hold", 32'(wd), 32'(m_word));

    // Glitch mid-word leaves the bit index alone.
    w = 24'($urandom);
    send_bits(w, 23, 14, 1'b1);
    hi(10);
    lo(100);
    send_bits(w, 13, 0, 1'b1);
    flush_check("glitch");

    // Over-long high drops a partial word.
    send_bits(24'($urandom), 23, 19, 1'b1);
    hi(400);
    lo(100);
    send_bits(24'($urandom), 23, 0, 1'b1);
    flush_check("overlong");

    // Frame gap in the middle of a word.
    send_bits(24'($urandom), 23, 12, 1'b1);
    lo(12000);
    send_bits(24'($urandom), 23, 0, 1'b1);
    flush_check("partial_gap");

    // Width boundaries: 105->0, 106->1, 20->0, 250->1, 19 glitch, 251 over-long.
    hi(105); lo(100);
    hi(106); lo(100);
    hi(20);  lo(100);
    hi(250); lo(100);
    hi(19);  lo(100);
    send_bits(24'($urandom), 19, 0, 1'b1);
    hi(251); lo(100);
    flush_check("boundary");
    chk("boundary_word_hold", 32'(wd), 32'(m_word));

    // Random legal traffic.
    send_bits(24'($urandom), 23, 0, 1'b1);
    send_bits(24'($urandom), 23, 0, 1'b1);
    flush_check("random");

    // Reset mid-word while the line is high, held high across release.
    send_bits(24'($urandom), 23, 17, 1'b1);
    din = 1'b1;
    repeat (30) @(negedge clk);
    flush_check("pre_reset");
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk_all_zero("mid_reset_outputs");
    rst_n = 1'b1;
    model_reset();
    hi(50);
    lo(100);
    chk_all_zero("post_reset_outputs");
    send_bits(24'($urandom), 23, 0, 1'b1);
    flush_check("after_reset");
    chk("final_word_hold", 32'(wd), 32'(m_word));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
